// File: rtl/sd_crc7.sv
// Bit-serial CRC7 (x^7 + x^3 + 1, init 0) for SD command/response tokens.
// A token is loaded on en_i and shifted MSB first, one bit per clock.
module sd_crc7 #(
    parameter int DATA_W = 40
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [6:0]        crc_o,
    output logic              crc_valid_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // One LFSR step: feedback taps land on bits 3 and 0.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        if (fb) begin
            crc7_step = {crc[5:0], 1'b0} ^ 7'h09;
        end else begin
            crc7_step = {crc[5:0], 1'b0};
        end
    endfunction

    state_e             state_q;
    logic [DATA_W-1:0]  sreg_q;
    logic [6:0]         lfsr_q;
    logic [6:0]         lfsr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [6:0]         crc_q;
    logic               crc_valid_q;

    // Next LFSR value for the bit currently at the head of the shift register.
    always_comb begin
        lfsr_d = crc7_step(lfsr_q, sreg_q[DATA_W-1]);
    end

    // Control FSM, shift datapath and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sreg_q      <= {DATA_W{1'b0}};
            lfsr_q      <= 7'h00;
            cnt_q       <= {CNT_W{1'b0}};
            crc_q       <= 7'h00;
            crc_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    crc_valid_q <= 1'b0;
                    if (en_i) begin
                        sreg_q  <= data_i;
                        lfsr_q  <= 7'h00;
                        cnt_q   <= {CNT_W{1'b0}};
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    lfsr_q <= lfsr_d;
                    sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
                    if (cnt_q == CNT_LAST) begin
                        // Counter parks at zero rather than wrapping through its range.
                        cnt_q       <= {CNT_W{1'b0}};
                        crc_q       <= lfsr_d;
                        crc_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q       <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        crc_valid_q <= 1'b0;
                    end
                end
                default: begin
                    crc_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign crc_o       = crc_q;
    assign crc_valid_o = crc_valid_q;

endmodule

// File: tb/tb_sd_crc7.sv
// Directed bench for sd_crc7 using well-known SD command/response CRC7 values.
module tb_sd_crc7;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic [39:0] data_i = 40'h0;
    logic [6:0]  crc_o;
    logic        crc_valid_o;

    int n_vec = 0;
    int n_err = 0;

    sd_crc7 #(.DATA_W(40)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .data_i      (data_i),
        .crc_o       (crc_o),
        .crc_valid_o (crc_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse en_i for one edge, then measure latency, result, hold and pulse width.
    task automatic run_cmd(input string tag, input logic [39:0] d,
                           input logic [6:0] exp_crc, input logic [6:0] prev_crc);
        int cyc;
        @(negedge clk_i);
        en_i   = 1'b1;
        data_i = d;
        @(posedge clk_i);
        @(negedge clk_i);
        en_i   = 1'b0;
        data_i = ~d;
        cyc = 0;
        while (!crc_valid_o && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
            if (cyc == 20) chk({tag, "_hold"}, {25'h0, crc_o}, {25'h0, prev_crc});
        end
        chk({tag, "_lat"}, cyc, 32'd40);
        chk({tag, "_crc"}, {25'h0, crc_o}, {25'h0, exp_crc});
        @(negedge clk_i);
        chk({tag, "_pw"}, {31'h0, crc_valid_o}, 32'd1 - 32'd1);
        chk({tag, "_keep"}, {25'h0, crc_o}, {25'h0, exp_crc});
    endtask

    initial begin
        int pulses;
        logic [6:0] seen;

        // Reset held 35 cycles while en_i is driven; nothing may start.
        en_i   = 1'b1;
        data_i = 40'h40_0000_0000;
        repeat (35) @(negedge clk_i);
        chk("rst_crc", {25'h0, crc_o}, 32'h0);
        chk("rst_valid", {31'h0, crc_valid_o}, 32'h0);
        en_i  = 1'b0;
        rst_i = 1'b0;
        pulses = 0;
        repeat (50) begin
            @(negedge clk_i);
            if (crc_valid_o) pulses++;
        end
        chk("rst_noen", pulses, 32'd0);

        run_cmd("cmd0",  40'h40_0000_0000, 7'h4A, 7'h00);
        run_cmd("cmd17", 40'h51_0000_0000, 7'h2A, 7'h4A);
        run_cmd("r1",    40'h11_0000_0900, 7'h33, 7'h2A);
        run_cmd("cmd0b", 40'h40_0000_0000, 7'h4A, 7'h33);

        // Busy: en_i re-pulsed at E10 of a CMD17 run must be ignored.
        @(negedge clk_i);
        en_i   = 1'b1;
        data_i = 40'h51_0000_0000;
        @(posedge clk_i);
        @(negedge clk_i);
        en_i = 1'b0;
        repeat (9) @(negedge clk_i);
        en_i   = 1'b1;
        data_i = 40'h40_0000_0000;
        @(posedge clk_i);
        @(negedge clk_i);
        en_i = 1'b0;
        pulses = 0;
        seen   = 7'h00;
        repeat (80) begin
            @(negedge clk_i);
            if (crc_valid_o) begin
                pulses++;
                seen = crc_o;
            end
        end
        chk("busy_pulses", pulses, 32'd1);
        chk("busy_crc", {25'h0, seen}, 32'h2A);

        // Abort: reset at E20 clears outputs immediately, no pulse follows.
        @(negedge clk_i);
        en_i   = 1'b1;
        data_i = 40'h51_0000_0000;
        @(posedge clk_i);
        @(negedge clk_i);
        en_i = 1'b0;
        repeat (19) @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        chk("abort_crc", {25'h0, crc_o}, 32'h0);
        chk("abort_valid", {31'h0, crc_valid_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        pulses = 0;
        repeat (60) begin
            @(negedge clk_i);
            if (crc_valid_o) pulses++;
        end
        chk("abort_nopulse", pulses, 32'd0);
        run_cmd("post_abort", 40'h40_0000_0000, 7'h4A, 7'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
